// File: rtl/fc_index_sequencer.sv
// fc_index_sequencer: buffers one frame of active spike indices and replays them once per output channel to the FC PE.
//   clk, rstn                    clock, asynchronous active-low reset
//   idx_in, idx_wr, frame_last   index write port from the spike producer; in_ready gates acceptance
//   stall                        downstream backpressure, freezes issue
//   s_index_ram, s_index_valid   replayed index stream to the PE
//   addr_most                    frame index count minus 1, stable during replay
//   channel_cnt                  output channel being issued
//   busy, layer_done, overflow   status: replay/drain active, completion pulse, sticky dropped-write flag
`ifndef SYNAPSE_INDEX
`define SYNAPSE_INDEX 7:0
`endif
`ifndef CONV1_ADDR
`define CONV1_ADDR 6:0
`endif
`ifndef CHANNEL_WIDE
`define CHANNEL_WIDE 7:0
`endif

module fc_index_sequencer #(
  parameter int INPUT_CHANNEL_NUM  = 128,
  parameter int OUTPUT_CHANNEL_NUM = 256,
  parameter int PIPE_LAT           = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [`SYNAPSE_INDEX] idx_in,
  input  logic                 idx_wr,
  input  logic                 frame_last,
  output logic                 in_ready,
  input  logic                 stall,
  output logic [`SYNAPSE_INDEX] s_index_ram,
  output logic                 s_index_valid,
  output logic [`CONV1_ADDR]    addr_most,
  output logic [`CHANNEL_WIDE]  channel_cnt,
  output logic                 busy,
  output logic                 layer_done,
  output logic                 overflow
);
  localparam int AW = $clog2(INPUT_CHANNEL_NUM);
  localparam int CW = AW + 1;
  localparam int HW = $clog2(OUTPUT_CHANNEL_NUM);
  localparam int DW = $clog2(PIPE_LAT + 1);
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, DONE} state_t;
  state_t state;
  logic [`SYNAPSE_INDEX] mem [INPUT_CHANNEL_NUM];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, fin;
  logic [DW-1:0] drain_cnt;
  logic loading, full, wr_ok, last_idx, last_ch;
  always_comb begin
    loading  = (state == IDLE) || (state == LOAD);
    full     = count == CW'(INPUT_CHANNEL_NUM);
    wr_ok    = loading && idx_wr && !full;
    // count including a write that coincides with frame_last
    fin      = count + CW'(wr_ok);
    last_idx = rd_ptr == addr_most;
    last_ch  = channel_cnt == HW'(OUTPUT_CHANNEL_NUM - 1);
  end
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= idx_in;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      drain_cnt     <= '0;
      in_ready      <= 1'b1;
      s_index_ram   <= '0;
      s_index_valid <= 1'b0;
      addr_most     <= '0;
      channel_cnt   <= '0;
      busy          <= 1'b0;
      layer_done    <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      layer_done <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (wr_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
            count  <= fin;
            state  <= LOAD;
          end
          if (idx_wr && full) overflow <= 1'b1;
          if (frame_last) begin
            in_ready <= 1'b0;
            if (fin == '0) begin
              layer_done <= 1'b1;
              state      <= DONE;
            end else begin
              addr_most   <= AW'(fin - CW'(1));
              rd_ptr      <= '0;
              channel_cnt <= '0;
              busy        <= 1'b1;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          s_index_valid <= !stall;
          if (!stall) begin
            s_index_ram <= mem[rd_ptr];
            rd_ptr      <= last_idx ? '0 : rd_ptr + AW'(1);
            if (last_idx) channel_cnt <= last_ch ? '0 : channel_cnt + HW'(1);
            if (last_idx && last_ch) begin
              drain_cnt <= '0;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          s_index_valid <= 1'b0;
          drain_cnt     <= drain_cnt + DW'(1);
          // the cycle holding the final valid is counted too, so done lands PIPE_LAT+1 after it
          if (drain_cnt == DW'(PIPE_LAT)) begin
            layer_done <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end
        end
        default: begin
          count    <= '0;
          wr_ptr   <= '0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_fc_index_sequencer.sv
// tb_fc_index_sequencer: randomized and directed checks of the index replay sequencer against a queue-based model.
module tb_fc_index_sequencer;
  localparam int N = 128;
  localparam int M = 256;
  localparam int LAT = 4;
  logic clk = 1'b0, rstn = 1'b0;
  logic [7:0] idx_in = '0;
  logic idx_wr = 1'b0, frame_last = 1'b0, stall = 1'b0;
  logic in_ready, s_index_valid, busy, layer_done, overflow;
  logic [7:0] s_index_ram, channel_cnt;
  logic [6:0] addr_most;
  int total = 0, passed = 0;
  int wq[$];
  bit ovf_m = 0;

  fc_index_sequencer dut (
    .clk(clk), .rstn(rstn), .idx_in(idx_in), .idx_wr(idx_wr), .frame_last(frame_last),
    .in_ready(in_ready), .stall(stall), .s_index_ram(s_index_ram), .s_index_valid(s_index_valid),
    .addr_most(addr_most), .channel_cnt(channel_cnt), .busy(busy), .layer_done(layer_done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic load_frame();
    for (int i = 0; i < wq.size(); i++) begin
      idx_wr = 1'b1;
      idx_in = 8'(wq[i]);
      frame_last = (i == wq.size() - 1);
      @(posedge clk); #1;
    end
    idx_wr = 1'b0;
    frame_last = 1'b0;
    if (wq.size() > N) ovf_m = 1;
  endtask

  task automatic check_idle_outputs(input string name);
    total++; if (in_ready !== 1'b1) $display("FAIL %s in_ready got %0b want 1", name, in_ready); else passed++;
    total++; if (s_index_valid !== 1'b0) $display("FAIL %s s_index_valid got %0b want 0", name, s_index_valid); else passed++;
    total++; if (s_index_ram !== 8'd0) $display("FAIL %s s_index_ram got %0d want 0", name, s_index_ram); else passed++;
    total++; if (addr_most !== 7'd0) $display("FAIL %s addr_most got %0d want 0", name, addr_most); else passed++;
    total++; if (channel_cnt !== 8'd0) $display("FAIL %s channel_cnt got %0d want 0", name, channel_cnt); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL %s busy got %0b want 0", name, busy); else passed++;
    total++; if (layer_done !== 1'b0) $display("FAIL %s layer_done got %0b want 0", name, layer_done); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL %s overflow got %0b want 0", name, overflow); else passed++;
  endtask

  // Loads wq as one frame and follows the whole replay; the model is the list of the first N
  // written indices, replayed M times, with channel number = floor((k+1)/n) after the k-th valid.
  task automatic run_frame(input string name, input int stall_at, input int stall_len, input bit rnd_stall);
    int n, nv, err, busy_err, gap, exp_gap, first, last, done_cyc, stall_left, bad_k, bad_ram, bad_ch;
    bit stalled_once;
    int exp_q[$];
    nv = 0; err = 0; busy_err = 0; gap = 0; exp_gap = 0; first = -1; last = -1; done_cyc = -1;
    stall_left = 0; stalled_once = 0; bad_k = -1; bad_ram = 0; bad_ch = 0;
    stall = 1'b0;
    load_frame();
    n = (wq.size() > N) ? N : wq.size();
    for (int i = 0; i < n; i++) exp_q.push_back(wq[i] & 255);
    total++; if (addr_most !== 7'(n - 1)) $display("FAIL %s addr_most got %0d want %0d", name, addr_most, n - 1); else passed++;
    total++; if (in_ready !== 1'b0 || busy !== 1'b1) $display("FAIL %s start in_ready/busy got %0b/%0b want 0/1", name, in_ready, busy); else passed++;
    for (int cyc = 1; cyc < 60000; cyc++) begin
      @(posedge clk); #1;
      if (s_index_valid) begin
        if (s_index_ram !== 8'(exp_q[nv % n]) || channel_cnt !== 8'(((nv + 1) / n) % M)) begin
          if (err == 0) begin bad_k = nv; bad_ram = s_index_ram; bad_ch = channel_cnt; end
          err++;
        end
        if (first < 0) first = cyc;
        last = cyc;
        nv++;
      end else if (first >= 0 && nv < n * M) gap++;
      if (layer_done) begin done_cyc = cyc; break; end
      if (busy !== 1'b1 || addr_most !== 7'(n - 1)) busy_err++;
      if (!stalled_once && stall_at >= 0 && nv == stall_at) begin stall_left = stall_len; stalled_once = 1; end
      if (stall_left > 0) begin stall = 1'b1; stall_left--; end
      else stall = rnd_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (stall && nv < n * M) exp_gap++;
    end
    stall = 1'b0;
    total++; if (done_cyc < 0) $display("FAIL %s layer_done timeout got none want pulse", name); else passed++;
    total++; if (nv !== n * M) $display("FAIL %s valid count got %0d want %0d", name, nv, n * M); else passed++;
    total++; if (err !== 0) $display("FAIL %s sequence errors got %0d want 0 (first at k=%0d ram=%0d ch=%0d want ram=%0d ch=%0d)",
                                     name, err, bad_k, bad_ram, bad_ch, (bad_k >= 0) ? exp_q[bad_k % n] : 0, ((bad_k + 1) / n) % M); else passed++;
    total++; if (first !== 1) $display("FAIL %s first valid cycle got %0d want 1", name, first); else passed++;
    total++; if (gap !== exp_gap) $display("FAIL %s stall gap cycles got %0d want %0d", name, gap, exp_gap); else passed++;
    total++; if (done_cyc - last !== LAT + 1) $display("FAIL %s done latency got %0d want %0d", name, done_cyc - last, LAT + 1); else passed++;
    total++; if (busy_err !== 0) $display("FAIL %s busy/addr_most hold errors got %0d want 0", name, busy_err); else passed++;
    total++; if (channel_cnt !== 8'd0 || busy !== 1'b0) $display("FAIL %s end ch/busy got %0d/%0b want 0/0", name, channel_cnt, busy); else passed++;
    total++; if (overflow !== ovf_m) $display("FAIL %s overflow got %0b want %0b", name, overflow, ovf_m); else passed++;
    @(posedge clk); #1;
    total++; if (layer_done !== 1'b0 || in_ready !== 1'b1) $display("FAIL %s after done layer_done/in_ready got %0b/%0b want 0/1", name, layer_done, in_ready); else passed++;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    wq = {3, 7, 9};
    run_frame("basic", -1, 0, 0);
  endtask

  task automatic test_stall();
    wq = {3, 7, 9};
    run_frame("stall", 17 * 3 + 1, 10, 0);
  endtask

  task automatic test_empty();
    bit saw_valid;
    frame_last = 1'b1;
    @(posedge clk); #1;
    frame_last = 1'b0;
    saw_valid = s_index_valid;
    total++; if (layer_done !== 1'b1) $display("FAIL empty layer_done got %0b want 1", layer_done); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL empty busy got %0b want 0", busy); else passed++;
    @(posedge clk); #1;
    saw_valid |= s_index_valid;
    total++; if (layer_done !== 1'b0 || in_ready !== 1'b1) $display("FAIL empty after layer_done/in_ready got %0b/%0b want 0/1", layer_done, in_ready); else passed++;
    total++; if (saw_valid !== 1'b0 || busy !== 1'b0) $display("FAIL empty valid/busy got %0b/%0b want 0/0", saw_valid, busy); else passed++;
  endtask

  task automatic test_single();
    wq = {42};
    run_frame("single", -1, 0, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(1, 12);
      wq = {};
      for (int i = 0; i < n; i++) wq.push_back($urandom_range(0, 255));
      run_frame("random", -1, 0, 1);
    end
  endtask

  task automatic test_overflow();
    wq = {};
    for (int i = 0; i < 130; i++) wq.push_back(i);
    run_frame("overflow", -1, 0, 0);
  endtask

  task automatic test_reset_mid();
    int waited;
    wq = {$urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255)};
    load_frame();
    waited = 0;
    while (channel_cnt !== 8'd100 && waited < 2000) begin
      @(posedge clk); #1;
      waited++;
    end
    total++; if (channel_cnt !== 8'd100) $display("FAIL reset_mid reach channel 100 got %0d want 100", channel_cnt); else passed++;
    #2 rstn = 1'b0;
    #1;
    ovf_m = 0;
    check_idle_outputs("reset_mid");
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    wq = {5, 6};
    run_frame("after_reset", -1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_empty();
    test_single();
    test_random();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fc_index_sequencer.md
Name: fc_index_sequencer

Overview:
- Controller that sequences the FC layer-1 processing element.
- Buffers one timestep's list of active input-spike indices, then replays the list once per output channel on the PE's s_index_ram/s_index_valid interface.
- Drives addr_most, tracks the output channel itself and signals layer completion after the PE pipeline drains.
- Sits between the spike-index producer (previous layer / encoder) and the FC PE.

Parameters:
- INPUT_CHANNEL_NUM, 128, buffer depth: maximum active indices per frame.
- OUTPUT_CHANNEL_NUM, 256, number of replays, one per output channel.
- PIPE_LAT, 4, PE latency from s_index_valid to mp_ready; used as the drain length.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- idx_in  in  `SYNAPSE_INDEX  incoming active input index.
- idx_wr  in  1  write strobe for idx_in; accepted only while in_ready=1.
- frame_last  in  1  marks the end of the frame. May coincide with idx_wr, in which case that index is included.
- in_ready  out  1  sequencer accepting indices.
- stall  in  1  downstream backpressure; freezes issue.
- s_index_ram  out  `SYNAPSE_INDEX  index presented to the PE.
- s_index_valid  out  1  index valid strobe to the PE.
- addr_most  out  `CONV1_ADDR  frame index count minus 1; held stable for the whole replay.
- channel_cnt  out  `CHANNEL_WIDE  output channel currently being issued.
- busy  out  1  high in ISSUE and DRAIN.
- layer_done  out  1  one-cycle completion pulse.
- overflow  out  1  sticky: an index write was dropped because the buffer was full.

Behaviour:
- Reset values: in_ready=1, s_index_valid=0, s_index_ram=0, addr_most=0, channel_cnt=0, busy=0, layer_done=0, overflow=0. All state, counters and the count register are cleared.
- All outputs are registered.
- Reset mid-operation aborts immediately. The buffer contents become don't-care; count=0.
- Storage: INPUT_CHANNEL_NUM x `SYNAPSE_INDEX register array.
  - wr_ptr has width clog2(INPUT_CHANNEL_NUM).
  - count has width clog2(INPUT_CHANNEL_NUM)+1.
- States: IDLE, LOAD, ISSUE, DRAIN, DONE.
- IDLE / LOAD (in_ready=1):
  - On idx_wr with count<INPUT_CHANNEL_NUM: store idx_in at wr_ptr and increment count. The first write moves the FSM to LOAD.
  - On idx_wr with count==INPUT_CHANNEL_NUM: drop the write and set overflow (sticky until reset).
  - On frame_last with final count==0 (empty frame): go to DONE. No s_index_valid is ever issued.
  - On frame_last with count>=1: latch addr_most=count-1, clear rd_ptr and channel_cnt, drop in_ready, go to ISSUE.
- ISSUE (in_ready=0; idx_wr ignored and does not set overflow):
  - Each cycle with stall=0: s_index_ram<=buf[rd_ptr], s_index_valid<=1.
  - If rd_ptr==count-1: rd_ptr wraps to 0 and channel_cnt increments.
  - Otherwise rd_ptr increments.
  - Cycles with stall=1: s_index_valid<=0 and all pointers hold. Resuming continues the sequence with no index skipped or repeated.
  - After issuing rd_ptr==count-1 with channel_cnt==OUTPUT_CHANNEL_NUM-1: go to DRAIN; channel_cnt wraps to 0.
  - Total valids per frame = count x OUTPUT_CHANNEL_NUM.
- DRAIN:
  - s_index_valid=0.
  - Counts PIPE_LAT cycles, starting the cycle after the final valid.
  - stall has no effect.
- DONE:
  - layer_done=1 for exactly one cycle.
  - count is cleared and in_ready returns to 1 on the next cycle, in IDLE.
- Timing:
  - layer_done rises PIPE_LAT+1 cycles after the last cycle in which s_index_valid=1.
  - First s_index_valid occurs 1 cycle after the frame_last acceptance cycle (stall low).
- Simultaneous frame_last with a full-buffer idx_wr: the write is dropped, overflow is set, and the frame proceeds with count=INPUT_CHANNEL_NUM.
- busy=1 exactly in ISSUE and DRAIN.

Test Plan:
- Write indices 3, 7, 9 (frame_last on 9), stall=0.
  - Expect 768 valids in the repeating pattern 3,7,9 with addr_most=2.
  - channel_cnt increments after each 9 and ends at 0.
  - layer_done comes 5 cycles after the final valid.
- Same frame with stall held high for 10 cycles mid-sequence (during channel 17).
  - Valid is low for those cycles; the sequence resumes without skip or repeat.
  - Total valid count is still 768.
- frame_last with no writes.
  - No valid issued; layer_done pulses 1 cycle later; busy stays 0.
- Write 130 indices (0..129), frame_last on the 130th.
  - overflow=1; addr_most=127; 128x256 valids, each replay being 0..127.
- Single index 42.
  - addr_most=0; 256 valids, all with s_index_ram=42; channel_cnt steps every cycle.
- Assert rstn low during channel 100 of a replay.
  - All outputs return to reset values at once; in_ready=1.
  - A fresh frame of indices 5, 6 then completes normally with 512 valids.
